// File: rtl/lsu_dmem_if.sv
// Data-memory interface stage: in-order store buffer draining to one memory port, loads bypass with priority.
// Define SB_FWD_EN to forward load data from matching buffered stores; otherwise a matching load stalls until drained.
module lsu_dmem_if #(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              st_en,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic [31:0]       ld_data,
  output logic              stall_out,
  input  logic              sb_flush,
  output logic              sb_empty,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic [31:0]       mem_rdata
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - 2;

`ifdef SB_FWD_EN
  typedef enum logic [1:0] {RESP_NONE, RESP_MEM, RESP_FWD} resp_e;
`else
  typedef enum logic {RESP_NONE, RESP_MEM} resp_e;
`endif

  logic [TAG_W-1:0] sb_addr_q [SB_DEPTH];
  logic [TAG_W-1:0] sb_addr_d [SB_DEPTH];
  logic [31:0]      sb_data_q [SB_DEPTH];
  logic [31:0]      sb_data_d [SB_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  resp_e            resp_q, resp_d;
  logic [31:0]      hold_q, hold_d;
`ifdef SB_FWD_EN
  logic [31:0]      fwd_q, fwd_d;
  logic [31:0]      hit_data;
`endif

  logic hit, full, flush_block, load_port, push, pop, req, we, stall;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{ld_addr[1:0], st_addr[1:0]};

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit = 1'b0;
`ifdef SB_FWD_EN
    hit_data = 32'h0;
`endif
    for (int k = 0; k < SB_DEPTH; k++) begin
      logic [PTR_W-1:0] idx;
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (sb_addr_q[idx] == ld_addr[ADDR_W-1:2])) begin
        hit = 1'b1;
`ifdef SB_FWD_EN
        hit_data = sb_data_q[idx];
`endif
      end
    end
  end

  always_comb begin
    full        = (count_q == CNT_W'(SB_DEPTH));
    flush_block = sb_flush && (count_q != '0);
    load_port   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    req         = 1'b0;
    we          = 1'b0;
    stall       = 1'b0;
    mem_addr    = {sb_addr_q[head_q], 2'b00};
    mem_wdata   = sb_data_q[head_q];
    resp_d      = RESP_NONE;
`ifdef SB_FWD_EN
    fwd_d       = fwd_q;
`endif

    if (ld_en) begin
      if (flush_block) begin
        stall = 1'b1;
      end else if (hit) begin
`ifdef SB_FWD_EN
        resp_d = RESP_FWD;
        fwd_d  = hit_data;
`else
        stall  = 1'b1;
`endif
      end else begin
        load_port = 1'b1;
        req       = 1'b1;
        mem_addr  = {ld_addr[ADDR_W-1:2], 2'b00};
        if (mem_gnt) resp_d = RESP_MEM;
        else         stall  = 1'b1;
      end
    end

    // Fullness is judged on the registered count, so a same-cycle pop does not admit the store.
    if (st_en) begin
      if (full) stall = 1'b1;
      else      push  = 1'b1;
    end

    if (!load_port && (count_q != '0)) begin
      req = 1'b1;
      we  = 1'b1;
      pop = mem_gnt;
    end

    sb_addr_d = sb_addr_q;
    sb_data_d = sb_data_q;
    if (push) begin
      sb_addr_d[tail_q] = st_addr[ADDR_W-1:2];
      sb_data_d[tail_q] = st_data;
    end
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    case (resp_q)
      RESP_MEM: ld_data = mem_rdata;
`ifdef SB_FWD_EN
      RESP_FWD: ld_data = fwd_q;
`endif
      default:  ld_data = hold_q;
    endcase
    hold_d = ld_data;
  end

  assign mem_req   = req && rst;
  assign mem_we    = we && rst;
  assign stall_out = stall && rst;
  assign sb_empty  = (count_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      resp_q  <= RESP_NONE;
      hold_q  <= '0;
`ifdef SB_FWD_EN
      fwd_q   <= '0;
`endif
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      resp_q    <= resp_d;
      hold_q    <= hold_d;
`ifdef SB_FWD_EN
      fwd_q     <= fwd_d;
`endif
      sb_addr_q <= sb_addr_d;
      sb_data_q <= sb_data_d;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Directed bench for lsu_dmem_if: load results and memory writes are checked against scoreboard queues.
// Forwarding expectations follow SB_FWD_EN exactly as the design build does.
module tb_lsu_dmem_if;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        st_en = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [31:0] ld_data;
  logic        stall_out;
  logic        sb_flush = 1'b0;
  logic        sb_empty;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] exp_ld_q [$];
  logic [63:0] exp_wr_q [$];
  logic        resp_due = 1'b0;
  logic [31:0] mem_model [logic [29:0]];
  logic        rd_fire = 1'b0;
  logic [31:0] rd_val = '0;
  logic [63:0] wr_e;

  always #5 clk = ~clk;

  lsu_dmem_if #(.SB_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ld_en(ld_en), .ld_addr(ld_addr),
    .st_en(st_en), .st_addr(st_addr), .st_data(st_data),
    .ld_data(ld_data), .stall_out(stall_out),
    .sb_flush(sb_flush), .sb_empty(sb_empty),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_read(input logic [29:0] w);
    if (mem_model.exists(w)) return mem_model[w];
    return {w, 2'b00} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: granted writes are matched in order against the store scoreboard.
  always @(negedge clk) begin
    rd_fire = 1'b0;
    if (rst && mem_req && mem_gnt) begin
      if (mem_we) begin
        n_checks++;
        assert (exp_wr_q.size() != 0) else begin
          n_err++;
          $error("[TB] FAIL spurious_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
        end
        if (exp_wr_q.size() != 0) begin
          wr_e = exp_wr_q.pop_front();
          check("wr_addr", mem_addr, wr_e[63:32]);
          check("wr_data", mem_wdata, wr_e[31:0]);
        end
        mem_model[mem_addr[31:2]] = mem_wdata;
      end else begin
        rd_fire = 1'b1;
        rd_val  = mem_read(mem_addr[31:2]);
      end
    end
  end

  always @(posedge clk) mem_rdata <= rd_fire ? rd_val : 32'h0BAD_F00D;

  task automatic applyStimulus(input logic ld, input logic [31:0] la, input logic st,
                               input logic [31:0] sa, input logic [31:0] sd,
                               input logic fl, input logic gnt);
    @(posedge clk);
    #1;
    ld_en = ld; ld_addr = la; st_en = st; st_addr = sa; st_data = sd;
    sb_flush = fl; mem_gnt = gnt;
  endtask

  task automatic checkOutput(input logic exp_stall, input logic [31:0] exp_ld);
    @(negedge clk);
    if (resp_due) check("ld_data", ld_data, exp_ld_q.pop_front());
    check("stall_out", {31'b0, stall_out}, {31'b0, exp_stall});
    resp_due = ld_en && !exp_stall;
    if (resp_due) exp_ld_q.push_back(exp_ld);
    if (st_en && !exp_stall) exp_wr_q.push_back({st_addr & ~32'h3, st_data});
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic gnt,
                          input logic exp_stall, input logic fl);
    applyStimulus(1'b0, 32'h0, 1'b1, a, d, fl, gnt);
    checkOutput(exp_stall, 32'h0);
  endtask

  task automatic do_load(input logic [31:0] a, input logic gnt, input logic exp_stall,
                         input logic [31:0] exp_d, input logic fl);
    applyStimulus(1'b1, a, 1'b0, 32'h0, 32'h0, fl, gnt);
    checkOutput(exp_stall, exp_d);
  endtask

  task automatic do_idle(input logic gnt);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, gnt);
    checkOutput(1'b0, 32'h0);
  endtask

  initial begin
    // Reset with a load pending: nothing may reach the memory port or hazard unit.
    ld_en = 1'b1; ld_addr = 32'h300;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_sb_empty", {31'b0, sb_empty}, 32'h1);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_stall", {31'b0, stall_out}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1; ld_en = 1'b0;

    // Load to a buffered store address.
    do_store(32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
`ifdef SB_FWD_EN
    do_load(32'h100, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    check("fwd_no_read", {31'b0, mem_req & ~mem_we}, 32'h0);
    do_idle(1'b0);
    do_idle(1'b1);
`else
    do_load(32'h100, 1'b0, 1'b1, 32'h0, 1'b0);
    do_load(32'h100, 1'b1, 1'b1, 32'h0, 1'b0);
    do_load(32'h100, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_idle(1'b0);
`endif
    do_idle(1'b0);
    check("t1_sb_empty", {31'b0, sb_empty}, 32'h1);

    // Two stores to one address: the younger value must be returned.
    do_store(32'h200, 32'h1, 1'b0, 1'b0, 1'b0);
    do_store(32'h200, 32'h2, 1'b0, 1'b0, 1'b0);
`ifdef SB_FWD_EN
    do_load(32'h200, 1'b0, 1'b0, 32'h2, 1'b0);
    do_idle(1'b1);
    do_idle(1'b1);
`else
    do_load(32'h200, 1'b0, 1'b1, 32'h0, 1'b0);
    do_load(32'h200, 1'b1, 1'b1, 32'h0, 1'b0);
    do_load(32'h200, 1'b1, 1'b1, 32'h0, 1'b0);
    do_load(32'h200, 1'b1, 1'b0, 32'h2, 1'b0);
    do_idle(1'b0);
`endif
    do_idle(1'b0);
    check("t2_sb_empty", {31'b0, sb_empty}, 32'h1);

    // Fill the buffer (pointers wrap), stall the fifth store, then release.
    for (int i = 0; i < 4; i++) do_store(32'h400 + 32'(4 * i), 32'h10 + 32'(i), 1'b0, 1'b0, 1'b0);
    check("full_sb_empty", {31'b0, sb_empty}, 32'h0);
    do_store(32'h410, 32'h14, 1'b0, 1'b1, 1'b0);
    do_store(32'h410, 32'h14, 1'b1, 1'b1, 1'b0);
    do_store(32'h410, 32'h14, 1'b1, 1'b0, 1'b0);
    repeat (3) do_idle(1'b1);
    do_idle(1'b0);
    check("t3_sb_empty", {31'b0, sb_empty}, 32'h1);
    check("t3_writes_done", 32'(exp_wr_q.size()), 32'h0);

    // Load miss held off by the grant while a drain waits behind it.
    do_store(32'h500, 32'h55, 1'b0, 1'b0, 1'b0);
    do_load(32'h303, 1'b0, 1'b1, 32'h0, 1'b0);
    check("miss_req", {31'b0, mem_req}, 32'h1);
    check("miss_we", {31'b0, mem_we}, 32'h0);
    check("miss_addr", mem_addr, 32'h300);
    do_load(32'h303, 1'b0, 1'b1, 32'h0, 1'b0);
    check("miss_we2", {31'b0, mem_we}, 32'h0);
    do_load(32'h303, 1'b1, 1'b0, 32'hC0DE_0300, 1'b0);
    check("miss_we3", {31'b0, mem_we}, 32'h0);
    do_idle(1'b1);
    do_idle(1'b0);

    // Fence: loads wait until both buffered stores have been written.
    do_store(32'h600, 32'h66, 1'b0, 1'b0, 1'b0);
    do_store(32'h604, 32'h67, 1'b0, 1'b0, 1'b1);
    do_load(32'h700, 1'b0, 1'b1, 32'h0, 1'b1);
    check("fl_sb_empty0", {31'b0, sb_empty}, 32'h0);
    do_load(32'h700, 1'b1, 1'b1, 32'h0, 1'b1);
    do_load(32'h700, 1'b1, 1'b1, 32'h0, 1'b1);
    do_load(32'h700, 1'b1, 1'b0, 32'hC0DE_0700, 1'b1);
    check("fl_sb_empty1", {31'b0, sb_empty}, 32'h1);
    do_idle(1'b0);
    do_idle(1'b0);
    check("ld_data_hold", ld_data, 32'hC0DE_0700);

    // Reset in the middle of draining three entries.
    for (int i = 0; i < 3; i++) do_store(32'h800 + 32'(4 * i), 32'h80 + 32'(i), 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_gnt = 1'b1; st_en = 1'b0;
    exp_wr_q.delete();
    resp_due = 1'b0;
    @(negedge clk);
    check("mid_rst_sb_empty", {31'b0, sb_empty}, 32'h1);
    check("mid_rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("mid_rst_ld_data", ld_data, 32'h0);
    check("mid_rst_stall", {31'b0, stall_out}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) do_idle(1'b1);
    check("post_rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("post_rst_sb_empty", {31'b0, sb_empty}, 32'h1);
    check("ld_q_drained", 32'(exp_ld_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
